crc8_checker: RTL and testbench
===============================

CRC8_CHECKER -- requirements
Module: crc8_checker

Interface
REQ-001 Parameter POLY, default 8'h07, meaning CRC-8 generator polynomial with the implicit x^8 term omitted.
REQ-002 Parameter INIT, default 8'h00, meaning CRC register value loaded at frame start.
REQ-003 Parameter MAX_BITS, default 1024, meaning the largest legal frame length in bits, CRC bits included.
REQ-004 Port clk, input, 1 bit, meaning the single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 Port start, input, 1 bit, meaning a one-cycle pulse that opens a new frame.
REQ-007 Port bit_in, input, 1 bit, meaning the serial data bit, MSB-first.
REQ-008 Port bit_valid, input, 1 bit, meaning bit_in is valid this cycle.
REQ-009 Port bit_last, input, 1 bit, meaning the current valid bit is the final bit of the frame; it is ignored unless bit_valid=1.
REQ-010 Port busy, output, 1 bit, meaning a frame is in progress.
REQ-011 Port done, output, 1 bit, meaning a one-cycle pulse that marks the result as valid.
REQ-012 Port crc_ok, output, 1 bit, meaning the last frame passed both the CRC check and the length check.
REQ-013 Port len_err, output, 1 bit, meaning the last frame had an illegal length.
REQ-014 Port bit_count, output, 11 bits, meaning the number of bits accepted in the current or last frame.

Function
REQ-015 The block SHALL be a receiver-side checker: the frame is payload bits followed by 8 CRC bits (MSB-first), and a frame is correct when the CRC residue over all bits equals 8'h00.
REQ-016 Each CRC step SHALL compute fb = crc[7] ^ bit_in, then crc_next = {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
REQ-017 The FSM SHALL have three states: IDLE, RECV and DONE.
REQ-018 IDLE: busy=0; on start, load crc=INIT, set bit_count=0, clear crc_ok and len_err, and go to RECV.
REQ-019 If bit_valid=1 in the same cycle as start, that bit SHALL be consumed as the first bit of the frame, with the CRC step applied to INIT.
REQ-020 RECV: busy=1; each cycle with bit_valid=1 SHALL apply one CRC step and increment bit_count; cycles with bit_valid=0 SHALL leave all state unchanged.
REQ-021 RECV with bit_valid=1 and bit_last=1 SHALL register the results and go to DONE on the next edge, giving a latency of 1 cycle from the last bit to done.
REQ-022 crc_ok SHALL be 1 only when all of the following hold: the final crc_next=8'h00, the final count is at least 16, and the final count is a multiple of 8.
REQ-023 len_err SHALL be 1 when the final count is below 16 or is not a multiple of 8.
REQ-024 If bit_count reaches MAX_BITS while in RECV with no bit_last, the block SHALL go to DONE with len_err=1 and crc_ok=0, and further bits SHALL be ignored.
REQ-025 start received while in RECV SHALL abort the current frame and restart it exactly as in IDLE, with no done pulse for the aborted frame.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE; start received in DONE SHALL be honoured as in IDLE.
REQ-027 crc_ok, len_err and bit_count SHALL hold their values until the next start or reset.
REQ-028 bit_valid received in IDLE without start SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force the IDLE state and clear every output: busy=0, done=0, crc_ok=0, len_err=0, bit_count=0, with the internal crc set to INIT.
REQ-030 A reset asserted mid-frame SHALL discard the frame, and no done pulse SHALL follow it.
REQ-031 Reset release SHALL take effect at the first clock edge after rst_n goes high.

Structure
REQ-032 A shared package crc8_pkg SHALL hold the state enum (IDLE/RECV/DONE), the default POLY, INIT and MAX_BITS constants, and the count width (11).
REQ-033 The single-bit CRC step SHALL be a purely combinational sub-module, crc8_step (inputs crc and bit, output crc_next), built from XOR2-style XOR gating.
REQ-034 All registers SHALL use clk and asynchronous rst_n only; there SHALL be no other clocks or gated clocks.

Verification
REQ-035 Frame 8'h01 followed by CRC 8'h07 (16 bits) -> one done pulse, crc_ok=1, len_err=0, bit_count=16.
REQ-036 Frame 8'h01 followed by 8'h06 -> done, crc_ok=0, len_err=0.
REQ-037 ASCII "123456789" followed by 8'hF4 (80 bits), with random bit_valid gaps -> crc_ok=1, bit_count=80.
REQ-038 A 12-bit frame ending in bit_last -> done, len_err=1, crc_ok=0; separately, 1024 bits with no bit_last -> done, len_err=1.
REQ-039 start pulsed mid-frame, then a good 16-bit frame -> exactly one done pulse with crc_ok=1; rst_n pulsed low mid-frame -> all outputs 0 and no done pulse.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared definitions for the serial CRC-8 frame checker: FSM states,
// default CRC parameters, counter width and the frame-length rule.
package crc8_pkg;

  // Frame checker control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default generator polynomial (x^8 term implicit), seed and frame limit
  localparam logic [7:0] DEFAULT_POLY     = 8'h07;
  localparam logic [7:0] DEFAULT_INIT     = 8'h00;
  localparam int         DEFAULT_MAX_BITS = 1024;

  // Bit counter width; must hold MAX_BITS itself
  localparam int CNT_W = 11;

  // Shortest legal frame: one payload byte plus the CRC byte
  localparam int MIN_FRAME_BITS = 16;

  // A frame length is legal when it is whole bytes and at least MIN_FRAME_BITS
  function automatic logic len_legal(input logic [CNT_W-1:0] n);
    return (n >= CNT_W'(MIN_FRAME_BITS)) && (n[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/crc8_step.sv
// One serial CRC-8 step: shifts a single MSB-first bit into the register.
// Purely combinational; every tap is a two-input XOR of the shifted bit
// with the feedback gated by the matching polynomial bit.
module crc8_step
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = DEFAULT_POLY
) (
  input  logic [7:0] crc,
  input  logic       bit_in,
  output logic [7:0] crc_next
);

  logic fb;

  assign fb = crc[7] ^ bit_in;

  // Bit 0 receives no shifted-in bit, only the gated feedback
  assign crc_next[0] = fb & POLY[0];

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_tap
      assign crc_next[gi] = crc[gi-1] ^ (fb & POLY[gi]);
    end
  endgenerate

endmodule

// File: rtl/crc8_checker.sv
// Receiver-side CRC-8 checker. Accepts a serial MSB-first frame (payload
// followed by the 8 CRC bits), runs the CRC over every bit and reports
// whether the residue is zero and the frame length is legal. Results are
// registered one cycle after the last bit and held until the next start.
module crc8_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY     = DEFAULT_POLY,
  parameter logic [7:0] INIT     = DEFAULT_INIT,
  parameter int         MAX_BITS = DEFAULT_MAX_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             bit_last,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_BITS);

  state_t           state_reg,   state_next;
  logic [7:0]       crc_reg,     crc_next;
  logic [CNT_W-1:0] count_reg,   count_next;
  logic             crc_ok_reg,  crc_ok_next;
  logic             len_err_reg, len_err_next;

  // Datapath operands: a start re-seeds the frame before the same-cycle bit
  logic [7:0]       crc_base;
  logic [7:0]       crc_stepped;
  logic [CNT_W-1:0] count_base;
  logic [CNT_W-1:0] count_stepped;
  logic             accept;

  assign crc_base      = start ? INIT : crc_reg;
  assign count_base    = start ? '0 : count_reg;
  assign count_stepped = count_base + 1'b1;

  // A bit is taken while receiving, or together with the start that opens a frame
  assign accept = bit_valid && (start || (state_reg == RECV));

  crc8_step #(
    .POLY(POLY)
  ) u_step (
    .crc      (crc_base),
    .bit_in   (bit_in),
    .crc_next (crc_stepped)
  );

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      crc_reg     <= INIT;
      count_reg   <= '0;
      crc_ok_reg  <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      count_reg   <= count_next;
      crc_ok_reg  <= crc_ok_next;
      len_err_reg <= len_err_next;
    end
  end

  // Next-state logic: frame open/abort, bit consumption and result capture
  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    count_next   = count_reg;
    crc_ok_next  = crc_ok_reg;
    len_err_next = len_err_reg;

    // Start opens a fresh frame from any state, silently dropping one in flight
    if (start) begin
      state_next   = RECV;
      crc_next     = INIT;
      count_next   = '0;
      crc_ok_next  = 1'b0;
      len_err_next = 1'b0;
    end

    if (accept) begin
      crc_next   = crc_stepped;
      count_next = count_stepped;
      if (bit_last) begin
        state_next   = DONE;
        crc_ok_next  = (crc_stepped == 8'h00) && len_legal(count_stepped);
        len_err_next = !len_legal(count_stepped);
      end else if (count_stepped == MAX_COUNT) begin
        // Runaway frame: close it as a length error and ignore what follows
        state_next   = DONE;
        crc_ok_next  = 1'b0;
        len_err_next = 1'b1;
      end
    end else if (!start && (state_reg == DONE)) begin
      state_next = IDLE;
    end
  end

  // Status outputs decode straight from registered state
  assign busy      = (state_reg == RECV);
  assign done      = (state_reg == DONE);
  assign crc_ok    = crc_ok_reg;
  assign len_err   = len_err_reg;
  assign bit_count = count_reg;

endmodule

// File: tb/tb_crc8_checker.sv
// Self-checking bench for crc8_checker: directed frames plus randomized
// frames judged by a polynomial long-division reference.
module tb_crc8_checker;

  localparam logic [7:0] POLY = 8'h07;

  typedef bit bitq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_last = 1'b0;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        len_err;
  logic [10:0] bit_count;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  crc8_checker #(
    .POLY     (POLY),
    .INIT     (8'h00),
    .MAX_BITS (1024)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .len_err   (len_err),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  // Count every done pulse seen on a rising edge
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bitq_t add_byte(input bitq_t q, input logic [7:0] b);
    bitq_t r = q;
    for (int i = 7; i >= 0; i--) r.push_back(b[i]);
    return r;
  endfunction

  // Remainder of F(x)*x^8 divided by G(x) = x^8 + POLY, by textbook long division
  function automatic logic [7:0] model_rem(input bitq_t m);
    logic [8:0] r = '0;
    for (int i = 0; i < m.size() + 8; i++) begin
      r = {r[7:0], (i < m.size()) ? m[i] : 1'b0};
      if (r[8]) r = r ^ {1'b1, POLY};
    end
    return r[7:0];
  endfunction

  function automatic bit model_len_ok(input int n);
    return (n >= 16) && (n % 8 == 0);
  endfunction

  // Drive one frame; returns right after the edge that takes the final bit
  task automatic send_bits(input bitq_t b, input bit with_last, input bit same, input int gap_pct);
    int idx = 0;
    start    = 1'b1;
    bit_last = 1'b0;
    if (!same) begin
      bit_valid = 1'b0;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("count_after_start", bit_count, 0);
    end
    while (idx < b.size()) begin
      if (start == 1'b0 && $urandom_range(99) < gap_pct) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1));
        bit_last  = 1'($urandom_range(1));
        tick();
        continue;
      end
      bit_in    = b[idx];
      bit_valid = 1'b1;
      bit_last  = with_last && (idx == b.size() - 1);
      tick();
      start = 1'b0;
      idx++;
    end
    bit_valid = 1'b0;
    bit_last  = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic check_result(input string tag, input bit e_ok, input bit e_le, input int e_cnt);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_crc_ok"}, crc_ok, e_ok);
    check({tag, "_len_err"}, len_err, e_le);
    check({tag, "_count"}, bit_count, e_cnt);
    $display("frame %s: bits=%0d crc_ok=%0b len_err=%0b", tag, e_cnt, e_ok, e_le);
  endtask

  initial begin
    bitq_t q;
    bitq_t good16;
    int    d0;
    int    n;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_len_err", len_err, 0);
    check("rst_count", bit_count, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // 0x01 + 0x07: good 16-bit frame
    good16 = {};
    good16 = add_byte(good16, 8'h01);
    good16 = add_byte(good16, 8'h07);
    d0 = done_cnt;
    send_bits(good16, 1'b1, 1'b0, 0);
    check_result("good16", 1'b1, 1'b0, 16);
    tick();
    check("good16_done_low", done, 0);
    check("good16_hold_ok", crc_ok, 1);
    check("good16_hold_count", bit_count, 16);
    check("good16_pulses", done_cnt - d0, 1);

    // Bits in IDLE without start are ignored
    bit_valid = 1'b1; bit_last = 1'b1; bit_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
    tick();
    check("idle_ignore_count", bit_count, 16);
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_pulses", done_cnt - d0, 1);

    // 0x01 + 0x06: bad CRC, legal length
    q = {};
    q = add_byte(q, 8'h01);
    q = add_byte(q, 8'h06);
    send_bits(q, 1'b1, 1'b0, 0);
    check_result("bad16", 1'b0, 1'b0, 16);
    tick();

    // "123456789" + 0xF4 with gaps, first bit alongside start
    q = {};
    for (int i = 1; i <= 9; i++) q = add_byte(q, 8'(8'h30 + i));
    q = add_byte(q, 8'hF4);
    send_bits(q, 1'b1, 1'b1, 30);
    check_result("check_str", 1'b1, 1'b0, 80);
    tick();

    // Randomized frames judged by the long-division model
    for (int f = 0; f < 10; f++) begin
      bitq_t pay;
      logic [7:0] c;
      int nb;
      bit e_ok;
      pay = {};
      nb = $urandom_range(8, 1);
      for (int k = 0; k < nb; k++) pay = add_byte(pay, 8'($urandom));
      c = model_rem(pay);
      q = add_byte(pay, c);
      if ($urandom_range(2) == 0) begin
        int p = $urandom_range(q.size() - 1);
        q[p] = ~q[p];
      end
      if ($urandom_range(3) == 0) begin
        n = $urandom_range(7, 1);
        for (int k = 0; k < n; k++) void'(q.pop_back());
      end
      e_ok = (model_rem(q) == 8'h00) && model_len_ok(q.size());
      send_bits(q, 1'b1, 1'($urandom_range(1)), $urandom_range(50));
      check_result($sformatf("rand%0d", f), e_ok, !model_len_ok(q.size()), q.size());
      tick();
    end

    // 12-bit frame: length error
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(1'($urandom_range(1)));
    send_bits(q, 1'b1, 1'b0, 10);
    check_result("short12", 1'b0, 1'b1, 12);
    tick();

    // 1024 bits with no bit_last: forced close at the limit
    q = {};
    for (int i = 0; i < 1024; i++) q.push_back(1'($urandom_range(1)));
    d0 = done_cnt;
    send_bits(q, 1'b0, 1'b0, 0);
    check_result("max1024", 1'b0, 1'b1, 1024);
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(); tick(); tick();
    bit_valid = 1'b0; bit_in = 1'b0;
    check("max_after_count", bit_count, 1024);
    check("max_after_busy", busy, 0);
    check("max_pulses", done_cnt - d0, 1);

    // Start mid-frame aborts it; only the restarted frame completes
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(1'($urandom_range(1)));
    d0 = done_cnt;
    send_bits(q, 1'b0, 1'b0, 0);
    check("abort_busy", busy, 1);
    send_bits(good16, 1'b1, 1'b1, 20);
    check_result("abort_restart", 1'b1, 1'b0, 16);
    tick();
    check("abort_pulses", done_cnt - d0, 1);

    // Start during the done cycle is honoured
    d0 = done_cnt;
    send_bits(good16, 1'b1, 1'b0, 0);
    check_result("back2back_a", 1'b1, 1'b0, 16);
    send_bits(q, 1'b1, 1'b1, 0);
    check_result("back2back_b", 1'b0, 1'b1, 5);
    tick();
    check("back2back_pulses", done_cnt - d0, 2);

    // Reset mid-frame: outputs clear at once, no done follows
    d0 = done_cnt;
    send_bits(good16, 1'b1, 1'b0, 0);
    check_result("pre_reset", 1'b1, 1'b0, 16);
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(1'($urandom_range(1)));
    send_bits(q, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_crc_ok", crc_ok, 0);
    check("midrst_len_err", len_err, 0);
    check("midrst_count", bit_count, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("postrst_busy", busy, 0);
    check("postrst_count", bit_count, 0);
    check("postrst_pulses", done_cnt - d0, 1);

    // Frame after reset still checks correctly
    send_bits(good16, 1'b1, 1'b1, 0);
    check_result("after_reset", 1'b1, 1'b0, 16);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
